// File: rtl/reg_file_pkg.sv
// Shared types and constants for the reg_file_sb register bank and its scoreboard.
package reg_file_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int ADDR_W_DEF   = 2;
    localparam int NUM_REGS_DEF = 1 << ADDR_W_DEF;

    typedef logic [NUM_REGS_DEF-1:0] busy_vec_t;

    // Error causes; any nonzero cause sets the sticky err flag.
    localparam logic [1:0] ERR_ISSUE_BUSY = 2'b01;
    localparam logic [1:0] ERR_WB_IDLE    = 2'b10;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: tracks in-flight destinations, issue acceptance, busy count and sticky error.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_wr_en,
    input  logic [ADDR_W-1:0]         i_wr_addr,
    input  logic                      i_iss_en,
    input  logic [ADDR_W-1:0]         i_iss_addr,
    output logic [(2**ADDR_W)-1:0]    o_busy,
    output logic                      o_iss_ready,
    output logic [ADDR_W:0]           o_busy_cnt,
    output logic                      o_err
);

    localparam int NUM_REGS = 2**ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [NUM_REGS-1:0] r_busy;
    logic [ADDR_W:0]     r_busy_cnt;
    logic                r_err;

    logic                w_iss_ready;
    logic                w_iss_acc;
    logic                w_clr_set;
    logic [1:0]          w_err_cause;
    logic [NUM_REGS-1:0] w_busy_nxt;

    always_comb begin
        w_iss_ready = !r_busy[i_iss_addr] || (i_wr_en && (i_wr_addr == i_iss_addr));
        w_iss_acc   = i_iss_en && w_iss_ready;
        w_clr_set   = i_wr_en && r_busy[i_wr_addr];
        w_err_cause = ((i_iss_en && !w_iss_ready)       ? ERR_ISSUE_BUSY : 2'b00)
                    | ((i_wr_en  && !r_busy[i_wr_addr]) ? ERR_WB_IDLE    : 2'b00);
        // Clear first so a same-register issue overrides the writeback clear.
        w_busy_nxt = r_busy;
        if (i_wr_en) w_busy_nxt[i_wr_addr] = 1'b0;
        if (w_iss_acc) w_busy_nxt[i_iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_err_cause != 2'b00) r_err <= 1'b1;
            case ({w_iss_acc, w_clr_set})
                2'b10:   r_busy_cnt <= r_busy_cnt + CNT_ONE;
                2'b01:   r_busy_cnt <= r_busy_cnt - CNT_ONE;
                default: r_busy_cnt <= r_busy_cnt;
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_iss_ready = w_iss_ready;
    assign o_busy_cnt  = r_busy_cnt;
    assign o_err       = r_err;

endmodule

// File: rtl/reg_file_sb.sv
// Register bank with two combinational read ports, one write port and a busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2,
    output logic              o_rd_busy1,
    output logic              o_rd_busy2,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_iss_en,
    input  logic [ADDR_W-1:0] i_iss_addr,
    output logic              o_iss_ready,
    output logic [ADDR_W:0]   o_busy_cnt,
    output logic              o_err
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;
    logic                w_byp1;
    logic                w_byp2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (i_wr_en) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    reg_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_iss_en    (i_iss_en),
        .i_iss_addr  (i_iss_addr),
        .o_busy      (w_busy),
        .o_iss_ready (o_iss_ready),
        .o_busy_cnt  (o_busy_cnt),
        .o_err       (o_err)
    );

`ifdef REG_FILE_BYPASS_EN
    assign w_byp1 = i_wr_en && (i_wr_addr == i_rd_addr1);
    assign w_byp2 = i_wr_en && (i_wr_addr == i_rd_addr2);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    // A forwarded read sees the writeback data and treats the register as settled.
    always_comb begin
        o_rd_data1 = w_byp1 ? i_wr_data : r_regs[i_rd_addr1];
        o_rd_data2 = w_byp2 ? i_wr_data : r_regs[i_rd_addr2];
        o_rd_busy1 = w_byp1 ? 1'b0 : w_busy[i_rd_addr1];
        o_rd_busy2 = w_byp2 ? 1'b0 : w_busy[i_rd_addr2];
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: driver pushes model predictions, negedge monitor compares.
module tb_reg_file_sb;
    import reg_file_pkg::*;

    localparam int NR = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0, iss_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0, iss_en = 1'b0;
    logic [7:0] rd_data1, rd_data2;
    logic       rd_busy1, rd_busy2, iss_ready, err;
    logic [2:0] busy_cnt;

    reg_file_sb dut (
        .clk         (clk),
        .reset       (reset),
        .i_rd_addr1  (rd_addr1),
        .i_rd_addr2  (rd_addr2),
        .o_rd_data1  (rd_data1),
        .o_rd_data2  (rd_data2),
        .o_rd_busy1  (rd_busy1),
        .o_rd_busy2  (rd_busy2),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_iss_en    (iss_en),
        .i_iss_addr  (iss_addr),
        .o_iss_ready (iss_ready),
        .o_busy_cnt  (busy_cnt),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d1, d2;
        logic       b1, b2, rdy, err;
        logic [2:0] cnt;
        int         id;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] m_regs [NR];
    busy_vec_t  m_busy;
    logic       m_err;

    function automatic void chk(string name, int id, logic [7:0] act, logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, id, act, expv);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        m_busy = '0;
        m_err  = 1'b0;
    endfunction

    function automatic exp_t predict(int id);
        exp_t e;
        e.id  = id;
        e.d1  = m_regs[rd_addr1];
        e.d2  = m_regs[rd_addr2];
        e.b1  = m_busy[rd_addr1];
        e.b2  = m_busy[rd_addr2];
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && wr_addr == rd_addr1) begin e.d1 = wr_data; e.b1 = 1'b0; end
        if (wr_en && wr_addr == rd_addr2) begin e.d2 = wr_data; e.b2 = 1'b0; end
`endif
        e.rdy = !m_busy[iss_addr] || (wr_en && wr_addr == iss_addr);
        e.cnt = 3'd0;
        for (int i = 0; i < NR; i++) e.cnt = e.cnt + 3'(m_busy[i]);
        e.err = m_err;
        return e;
    endfunction

    // Architectural effect of one clock edge, from the current (held) inputs.
    function automatic void model_edge();
        logic [1:0] cause;
        logic       rdy;
        if (reset) return;
        rdy   = !m_busy[iss_addr] || (wr_en && wr_addr == iss_addr);
        cause = 2'b00;
        if (iss_en && !rdy) cause = cause | ERR_ISSUE_BUSY;
        if (wr_en && !m_busy[wr_addr]) cause = cause | ERR_WB_IDLE;
        if (wr_en) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
        end
        if (iss_en && rdy) m_busy[iss_addr] = 1'b1;
        if (cause != 2'b00) m_err = 1'b1;
    endfunction

    // Called just after a rising edge; leaves time just after the next rising edge.
    task automatic step(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                        input logic ie, input logic [1:0] ia,
                        input logic [1:0] ra1, input logic [1:0] ra2, input int id);
        wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_addr = ia;
        rd_addr1 = ra1; rd_addr2 = ra2;
        q.push_back(predict(id));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset(input int id);
        wr_en = 1'b0; iss_en = 1'b0;
        reset = 1'b1;
        model_clear();
        q.push_back(predict(id));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rd_data1",  e.id, rd_data1, e.d1);
            chk("rd_data2",  e.id, rd_data2, e.d2);
            chk("rd_busy1",  e.id, {7'd0, rd_busy1}, {7'd0, e.b1});
            chk("rd_busy2",  e.id, {7'd0, rd_busy2}, {7'd0, e.b2});
            chk("iss_ready", e.id, {7'd0, iss_ready}, {7'd0, e.rdy});
            chk("busy_cnt",  e.id, {5'd0, busy_cnt}, {5'd0, e.cnt});
            chk("err",       e.id, {7'd0, err}, {7'd0, e.err});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        do_reset(0);

        // Reset clears stored data
        step(1, 2, 8'hA5, 0, 0, 2, 2, 1);
        step(0, 0, 8'h00, 0, 0, 2, 2, 2);
        do_reset(3);
        step(0, 0, 8'h00, 0, 0, 2, 2, 4);

        // Write/read and hold
        step(1, 1, 8'h3C, 0, 0, 0, 0, 5);
        step(1, 3, 8'hFF, 0, 0, 0, 0, 6);
        step(0, 0, 8'h00, 0, 0, 1, 3, 7);
        step(0, 0, 8'h00, 0, 0, 1, 3, 8);

        // Issue, double issue, writeback
        do_reset(9);
        step(0, 0, 8'h00, 1, 2, 2, 2, 10);
        step(0, 0, 8'h00, 1, 2, 2, 2, 11);
        step(1, 2, 8'h11, 0, 0, 2, 2, 12);
        step(0, 0, 8'h00, 0, 2, 2, 2, 13);

        // Same-cycle writeback and re-issue of r1
        do_reset(14);
        step(0, 0, 8'h00, 1, 1, 1, 1, 15);
        step(1, 1, 8'h22, 1, 1, 1, 1, 16);
        step(0, 0, 8'h00, 0, 1, 1, 1, 17);

        // Bypass window on r0
        step(0, 0, 8'h00, 1, 0, 0, 0, 18);
        step(1, 0, 8'h5A, 0, 0, 0, 1, 19);
        step(0, 0, 8'h00, 0, 0, 0, 1, 20);

        // Fill the scoreboard, then reset mid-cycle with a write pending
        do_reset(21);
        for (int i = 0; i < NR; i++) step(0, 0, 8'h00, 1, 2'(i), 0, 1, 22 + i);
        step(0, 0, 8'h00, 0, 0, 0, 1, 26);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h77;
        iss_en = 1'b0; rd_addr1 = 2'd1; rd_addr2 = 2'd2;
        #2;
        reset = 1'b1;
        model_clear();
        q.push_back(predict(27));
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        reset = 1'b0;
        step(0, 0, 8'h00, 0, 0, 0, 3, 28);
        step(0, 0, 8'h00, 0, 0, 0, 0, 29);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset(1000 + n);
            end else begin
                step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1000 + n);
            end
        end

        wr_en = 1'b0; iss_en = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
